aes_encrypt_core_param: RTL and testbench

Iterative, one-round-per-cycle AES encryption core, parametrised for 128/192/256-bit keys (Nr = 10/12/14). Takes one plaintext block per valid/ready transaction. Consumes one externally expanded round key per cycle, indexed by round_num. Returns the ciphertext on a valid/ready output channel that holds the result under backpressure. Sits between the block-cipher mode controller (upstream) and the key-expansion/round-key store (sideband).

---
 rtl/aes_encrypt_core_param_if.sv | 24 ++
 rtl/aes_encrypt_core_param.sv | 141 ++++++++++++++
 tb/tb_aes_encrypt_core_param.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_encrypt_core_param_if.sv
// Plaintext/ciphertext handshake and round-key sideband bundle for aes_encrypt_core_param.
// The master drives blocks, round keys and out_ready; the slave is the core.
interface aes_encrypt_core_param_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plain_text;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         round_key_en;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] cipher_text;
  logic         busy;

  modport master (
    output in_valid, plain_text, round_key, out_ready,
    input  in_ready, round_num, round_key_en, out_valid, cipher_text, busy
  );

  modport slave (
    input  in_valid, plain_text, round_key, out_ready,
    output in_ready, round_num, round_key_en, out_valid, cipher_text, busy
  );
endinterface

// File: rtl/aes_encrypt_core_param.sv
// Iterative AES encryption core, one round per cycle, round keys fetched by round_num.
// Define AES_ENC_ABORT_EN to add the abort input that drops an in-flight block.
module aes_encrypt_core_param #(
  parameter int KEY_LEN = 128
) (
  input  logic clk,
  input  logic reset_n,
`ifdef AES_ENC_ABORT_EN
  input  logic abort,
`endif
  aes_encrypt_core_param_if.slave bus
);

  if (KEY_LEN != 128 && KEY_LEN != 192 && KEY_LEN != 256) begin : g_bad_key_len
    $error("aes_encrypt_core_param: KEY_LEN must be 128, 192 or 256");
  end

  localparam int         NR  = (KEY_LEN == 256) ? 14 : (KEY_LEN == 192) ? 12 : 10;
  localparam logic [3:0] NR4 = 4'(NR);

  // Byte 0 of the block (bits 127:120) sits at index 15.
  typedef logic [15:0][7:0] blk_t;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  blk_t       st_q, st_d;
  blk_t       ct_q, ct_d;
  blk_t       sb, sr, mc;

  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sb[i] = sbox(st_q[i]);
  end

  assign sr = {sb[15], sb[10], sb[5],  sb[0],
               sb[11], sb[6],  sb[1],  sb[12],
               sb[7],  sb[2],  sb[13], sb[8],
               sb[3],  sb[14], sb[9],  sb[4]};

  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[15-4*c];
    assign a1 = sr[14-4*c];
    assign a2 = sr[13-4*c];
    assign a3 = sr[12-4*c];
    assign mc[15-4*c] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc[14-4*c] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc[13-4*c] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc[12-4*c] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    st_d    = st_q;
    ct_d    = ct_q;
    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (bus.in_valid) begin
          st_d    = bus.plain_text ^ bus.round_key;
          cnt_d   = 4'd1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (cnt_q < NR4) begin
          st_d  = mc ^ bus.round_key;
          cnt_d = cnt_q + 4'd1;
        end else if (cnt_q == NR4) begin
          st_d    = sr ^ bus.round_key;
          ct_d    = sr ^ bus.round_key;
          cnt_d   = 4'd0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    // An out-of-range counter can only come from an upset; recover to IDLE.
    if (state_q != IDLE && cnt_q > NR4) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end
`ifdef AES_ENC_ABORT_EN
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      st_d    = '0;
      ct_d    = ct_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      st_q    <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      ct_q    <= ct_d;
    end
  end

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.round_key_en = (state_q == IDLE) ? bus.in_valid : (state_q == ROUND);
  assign bus.round_num    = (state_q == ROUND) ? cnt_q : 4'd0;
  assign bus.out_valid    = (state_q == DONE);
  assign bus.cipher_text  = ct_q;
  assign bus.busy         = (state_q == ROUND) || (state_q == DONE);

endmodule

// File: tb/tb_aes_encrypt_core_param.sv
// Bench for aes_encrypt_core_param: one instance per key length, driven against an AES model.
module tb_aes_encrypt_core_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         in_valid   [3];
  logic [127:0] plain_text [3];
  logic         out_ready  [3];
`ifdef AES_ENC_ABORT_EN
  logic         abort      [3];
`endif
  wire          in_ready_o [3];
  wire  [3:0]   rn_o       [3];
  wire          rke_o      [3];
  wire          ov_o       [3];
  wire  [127:0] ct_o       [3];
  wire          busy_o     [3];

  logic [127:0] rk_tab [3][16];
  logic [7:0]   sb [256];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           rn_q [$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_encrypt_core_param_if ifc ();
    assign ifc.in_valid   = in_valid[g];
    assign ifc.plain_text = plain_text[g];
    assign ifc.out_ready  = out_ready[g];
    assign ifc.round_key  = rk_tab[g][ifc.round_num];
    assign in_ready_o[g]  = ifc.in_ready;
    assign rn_o[g]        = ifc.round_num;
    assign rke_o[g]       = ifc.round_key_en;
    assign ov_o[g]        = ifc.out_valid;
    assign ct_o[g]        = ifc.cipher_text;
    assign busy_o[g]      = ifc.busy;
    aes_encrypt_core_param #(.KEY_LEN(128 + 64 * g)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
`ifdef AES_ENC_ABORT_EN
      .abort   (abort[g]),
`endif
      .bus     (ifc.slave)
    );
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box from the GF(2^8) inverse plus affine map.
  task automatic init_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // Key bytes are 00,01,02,... for every key length.
  task automatic expand_key(input int d);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    int nk, nr;
    nk = 4 + 2 * d;
    nr = 10 + 2 * d;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++)
      w[i] = {8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)};
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i - 1];
      if (i % nk == 0) begin
        t = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i - nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk_tab[d][r] = (r <= nr) ? {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]} : 128'h0;
  endtask

  function automatic logic [127:0] ref_enc(input int d, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] k, res;
    int nr;
    nr = 10 + 2 * d;
    k = rk_tab[d][0];
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ k[127 - 8 * i -: 8];
    for (int r = 1; r <= nr; r++) begin
      k = rk_tab[d][r];
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) s[4 * c + w] = t[4 * ((c + w) % 4) + w];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4 * c]; a1 = s[4 * c + 1]; a2 = s[4 * c + 2]; a3 = s[4 * c + 3];
          s[4 * c]     = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
          s[4 * c + 1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
          s[4 * c + 2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
          s[4 * c + 3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127 - 8 * i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offers one block with out_ready=1 and waits for the result; records round_num while keys are used.
  task automatic do_block(input int d, input logic [127:0] pt, output logic [127:0] ct,
                          output int lat, output bit tmo);
    int w;
    tmo = 1'b0;
    rn_q.delete();
    @(negedge clk);
    in_valid[d] = 1'b1; plain_text[d] = pt; out_ready[d] = 1'b1;
    #1;
    w = 0;
    while (!in_ready_o[d] && w < 50) begin @(negedge clk); w++; end
    if (!in_ready_o[d]) tmo = 1'b1;
    if (rke_o[d]) rn_q.push_back(int'(rn_o[d]));
    @(posedge clk);
    @(negedge clk);
    in_valid[d] = 1'b0;
    lat = 0;
    while (!ov_o[d] && lat < 40) begin
      if (rke_o[d]) rn_q.push_back(int'(rn_o[d]));
      @(negedge clk);
      lat++;
    end
    if (!ov_o[d]) tmo = 1'b1;
    ct = ct_o[d];
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      n_checks++; if (in_ready_o[d] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready[%0d]: got %b required 1", d, in_ready_o[d]); end
      n_checks++; if (ov_o[d] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid[%0d]: got %b required 0", d, ov_o[d]); end
      n_checks++; if (ct_o[d] !== 128'h0) begin n_fail++; $display("FAIL reset_cipher_text[%0d]: got %h required 0", d, ct_o[d]); end
      n_checks++; if (rn_o[d] !== 4'd0) begin n_fail++; $display("FAIL reset_round_num[%0d]: got %0d required 0", d, rn_o[d]); end
      n_checks++; if (rke_o[d] !== 1'b0) begin n_fail++; $display("FAIL reset_round_key_en[%0d]: got %b required 0", d, rke_o[d]); end
      n_checks++; if (busy_o[d] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b required 0", d, busy_o[d]); end
    end
  endtask

  task automatic test_kat(input int d);
    logic [127:0] pt, kat, ct;
    int lat;
    bit tmo, ok;
    pt = 128'h00112233445566778899aabbccddeeff;
    case (d)
      0:       kat = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      1:       kat = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
      default: kat = 128'h8ea2b7ca516745bfeafc49904b496089;
    endcase
    do_block(d, pt, ct, lat, tmo);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL kat%0d_timeout: handshake not completed, required completion", d); end
    n_checks++; if (ct !== kat) begin n_fail++; $display("FAIL kat%0d_cipher_text: got %h required %h", d, ct, kat); end
    n_checks++; if (ct !== ref_enc(d, pt)) begin n_fail++; $display("FAIL kat%0d_model: got %h required %h", d, ct, ref_enc(d, pt)); end
    n_checks++; if (lat != 10 + 2 * d) begin n_fail++; $display("FAIL kat%0d_latency: got %0d edges required %0d", d, lat, 10 + 2 * d); end
    ok = (rn_q.size() == 11 + 2 * d);
    foreach (rn_q[i]) if (rn_q[i] != i) ok = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL kat%0d_round_num_seq: got %0d entries required 0..%0d in order", d, rn_q.size(), 10 + 2 * d); end
    @(negedge clk);
    n_checks++; if (ov_o[d] !== 1'b0 || in_ready_o[d] !== 1'b1) begin n_fail++; $display("FAIL kat%0d_release: got out_valid=%b in_ready=%b required 0/1", d, ov_o[d], in_ready_o[d]); end
  endtask

  task automatic test_random(input int d);
    logic [127:0] pt, ct;
    int lat;
    bit tmo;
    for (int k = 0; k < 3; k++) begin
      pt = rand128();
      do_block(d, pt, ct, lat, tmo);
      n_checks++; if (tmo || ct !== ref_enc(d, pt)) begin n_fail++; $display("FAIL random%0d_%0d: got %h required %h", d, k, ct, ref_enc(d, pt)); end
    end
  endtask

  task automatic test_backpressure(input int d);
    logic [127:0] pt, exp_ct;
    int w, bad;
    pt = rand128();
    exp_ct = ref_enc(d, pt);
    @(negedge clk);
    in_valid[d] = 1'b1; plain_text[d] = pt; out_ready[d] = 1'b0;
    #1;
    w = 0;
    while (!in_ready_o[d] && w < 50) begin @(negedge clk); w++; end
    @(posedge clk);
    @(negedge clk);
    in_valid[d] = 1'b0;
    w = 0;
    while (!ov_o[d] && w < 40) begin @(negedge clk); w++; end
    n_checks++; if (!ov_o[d]) begin n_fail++; $display("FAIL bp%0d_timeout: out_valid never rose, required rise", d); end
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (ov_o[d] !== 1'b1 || ct_o[d] !== exp_ct || in_ready_o[d] !== 1'b0) bad++;
      @(negedge clk);
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp%0d_hold: got %0d unstable cycles required 0 (ct %h expected %h)", d, bad, ct_o[d], exp_ct); end
    out_ready[d] = 1'b1;
    @(negedge clk);
    n_checks++; if (ov_o[d] !== 1'b0 || in_ready_o[d] !== 1'b1) begin n_fail++; $display("FAIL bp%0d_release: got out_valid=%b in_ready=%b required 0/1", d, ov_o[d], in_ready_o[d]); end
    n_checks++; if (ct_o[d] !== exp_ct) begin n_fail++; $display("FAIL bp%0d_ct_after: got %h required %h", d, ct_o[d], exp_ct); end
  endtask

  task automatic test_back_to_back(input int d);
    logic [127:0] a, b, outs [2];
    int acc_cyc [2];
    int cyc, n_acc, n_out, leak;
    a = rand128();
    b = rand128();
    outs[0] = '0; outs[1] = '0; acc_cyc[0] = 0; acc_cyc[1] = 0;
    @(negedge clk);
    in_valid[d] = 1'b1; plain_text[d] = a; out_ready[d] = 1'b1;
    #1;
    cyc = 0; n_acc = 0; n_out = 0; leak = 0;
    while (cyc < 100 && (n_acc < 2 || n_out < 2)) begin
      if (ov_o[d] && n_out < 2) begin outs[n_out] = ct_o[d]; n_out++; end
      if (busy_o[d] && in_ready_o[d]) leak++;
      if (in_ready_o[d] && in_valid[d] && n_acc < 2) begin acc_cyc[n_acc] = cyc; n_acc++; end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (n_acc == 2) in_valid[d] = 1'b0;
      else if (in_ready_o[d]) plain_text[d] = b;
      else plain_text[d] = rand128();
      #1;
    end
    in_valid[d] = 1'b0;
    n_checks++; if (n_acc != 2 || n_out != 2) begin n_fail++; $display("FAIL b2b%0d_timeout: got %0d accepts %0d outputs required 2/2", d, n_acc, n_out); end
    n_checks++; if (outs[0] !== ref_enc(d, a)) begin n_fail++; $display("FAIL b2b%0d_first: got %h required %h", d, outs[0], ref_enc(d, a)); end
    n_checks++; if (outs[1] !== ref_enc(d, b)) begin n_fail++; $display("FAIL b2b%0d_second: got %h required %h", d, outs[1], ref_enc(d, b)); end
    n_checks++; if (acc_cyc[1] - acc_cyc[0] != 12 + 2 * d) begin n_fail++; $display("FAIL b2b%0d_spacing: got %0d cycles required %0d", d, acc_cyc[1] - acc_cyc[0], 12 + 2 * d); end
    n_checks++; if (leak != 0) begin n_fail++; $display("FAIL b2b%0d_ready_while_busy: got %0d cycles required 0", d, leak); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] pt, ct;
    int w, lat;
    bit tmo;
    @(negedge clk);
    in_valid[0] = 1'b1; plain_text[0] = rand128(); out_ready[0] = 1'b1;
    #1;
    w = 0;
    while (!in_ready_o[0] && w < 50) begin @(negedge clk); w++; end
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    w = 0;
    while (rn_o[0] != 4'd5 && w < 30) begin @(negedge clk); w++; end
    n_checks++; if (rn_o[0] !== 4'd5) begin n_fail++; $display("FAIL rstmid_reach_round5: got %0d required 5", rn_o[0]); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (busy_o[0] !== 1'b0 || in_ready_o[0] !== 1'b1) begin n_fail++; $display("FAIL rstmid_state: got busy=%b in_ready=%b required 0/1", busy_o[0], in_ready_o[0]); end
    n_checks++; if (ov_o[0] !== 1'b0 || ct_o[0] !== 128'h0) begin n_fail++; $display("FAIL rstmid_outputs: got out_valid=%b ct=%h required 0/0", ov_o[0], ct_o[0]); end
    n_checks++; if (rn_o[0] !== 4'd0 || rke_o[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_key_port: got round_num=%0d en=%b required 0/0", rn_o[0], rke_o[0]); end
    @(negedge clk);
    reset_n = 1'b1;
    pt = rand128();
    do_block(0, pt, ct, lat, tmo);
    n_checks++; if (tmo || ct !== ref_enc(0, pt) || lat != 10) begin n_fail++; $display("FAIL rstmid_next_block: got %h lat %0d required %h lat 10", ct, lat, ref_enc(0, pt)); end
  endtask

`ifdef AES_ENC_ABORT_EN
  task automatic test_abort();
    logic [127:0] pt, ct;
    int w, lat, seen;
    bit tmo;
    @(negedge clk);
    in_valid[0] = 1'b1; plain_text[0] = rand128(); out_ready[0] = 1'b1;
    #1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    w = 0;
    while (rn_o[0] != 4'd3 && w < 30) begin @(negedge clk); w++; end
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    n_checks++; if (busy_o[0] !== 1'b0 || in_ready_o[0] !== 1'b1 || ov_o[0] !== 1'b0) begin n_fail++; $display("FAIL abort_round: got busy=%b in_ready=%b ov=%b required 0/1/0", busy_o[0], in_ready_o[0], ov_o[0]); end
    seen = 0;
    for (int k = 0; k < 15; k++) begin if (ov_o[0]) seen++; @(negedge clk); end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL abort_no_output: got %0d out_valid cycles required 0", seen); end
    pt = 128'h00112233445566778899aabbccddeeff;
    do_block(0, pt, ct, lat, tmo);
    n_checks++; if (tmo || ct !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin n_fail++; $display("FAIL abort_next_kat: got %h required 69c4e0d86a7b0430d8cdb78070b4c55a", ct); end
    // abort while holding a result
    @(negedge clk);
    in_valid[0] = 1'b1; plain_text[0] = rand128(); out_ready[0] = 1'b0;
    #1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    w = 0;
    while (!ov_o[0] && w < 40) begin @(negedge clk); w++; end
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    out_ready[0] = 1'b1;
    n_checks++; if (ov_o[0] !== 1'b0 || in_ready_o[0] !== 1'b1) begin n_fail++; $display("FAIL abort_done: got ov=%b in_ready=%b required 0/1", ov_o[0], in_ready_o[0]); end
    // abort in IDLE must not block acceptance
    pt = rand128();
    abort[0] = 1'b1; in_valid[0] = 1'b1; plain_text[0] = pt;
    #1;
    @(posedge clk);
    @(negedge clk);
    abort[0] = 1'b0; in_valid[0] = 1'b0;
    n_checks++; if (busy_o[0] !== 1'b1) begin n_fail++; $display("FAIL abort_idle_ignored: got busy=%b required 1", busy_o[0]); end
    w = 0;
    while (!ov_o[0] && w < 40) begin @(negedge clk); w++; end
    n_checks++; if (ct_o[0] !== ref_enc(0, pt)) begin n_fail++; $display("FAIL abort_idle_result: got %h required %h", ct_o[0], ref_enc(0, pt)); end
    @(negedge clk);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; plain_text[d] = '0; out_ready[d] = 1'b0;
`ifdef AES_ENC_ABORT_EN
      abort[d] = 1'b0;
`endif
    end
    init_sbox();
    for (int d = 0; d < 3; d++) expand_key(d);
    #23;
    test_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int d = 0; d < 3; d++) test_kat(d);
    for (int d = 0; d < 3; d++) test_random(d);
    test_backpressure(0);
    test_backpressure(2);
    for (int d = 0; d < 3; d++) test_back_to_back(d);
    test_reset_mid();
`ifdef AES_ENC_ABORT_EN
    test_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
